sram_read_streamer: RTL and testbench
=====================================

# sram_read_streamer

Read-side sequencer directly downstream of the 256×32 operand SRAM in the RSA datapath. On a start command it reads a contiguous run of words from the SRAM, hides the SRAM's one-cycle read latency behind a 2-entry prefetch buffer, and presents the words on a valid/ready stream to the modular-arithmetic core. It never writes the SRAM.

## Interface
Parameters:
- ADDR_W, 8, SRAM address width (depth 2^ADDR_W words)
- DATA_W, 32, SRAM word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only when busy=0
- base  in  ADDR_W  first word address
- len  in  ADDR_W+1  word count, 0..256
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- sram_en  out  1  SRAM enable
- sram_wen  out  1  SRAM write enable, active-low; constant 1
- sram_addr  out  ADDR_W  SRAM address
- sram_q  in  DATA_W  SRAM read data, valid the cycle after the enabled edge
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  stream word
- out_last  out  1  marks final word of the transfer

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE: busy=0. start=1 with len≥1 -> RUN, load address pointer and issue counter = len, remaining-out counter = len. start=1 with len=0 -> stay IDLE, done pulses the next cycle, no SRAM access.
- RUN: issue a read (sram_en=1, sram_addr=pointer) in a cycle only if buffer occupancy + reads in flight < 2 and issue counter > 0; on issue, pointer advances by 1 modulo 2^ADDR_W, issue counter decrements. When issue counter reaches 0 -> FLUSH.
- FLUSH: no further reads; drain buffer. When the word with out_last is accepted -> IDLE, done=1 for one cycle.
- Read data captured into the buffer at the edge following the issue cycle (in-flight flag tracks this).
- Buffer: 2-entry FIFO; out_data/out_valid driven from its head; handshake = out_valid & out_ready pops one entry; push and pop in the same cycle allowed.
- out_last = out_valid & (remaining-out counter == 1). Remaining-out decrements on each handshake.
- Address wrap: base=0xFE, len=4 reads 0xFE, 0xFF, 0x00, 0x01.
- start while busy=1 ignored; base/len sampled only at the accepting edge.
- sram_addr holds its last value when sram_en=0.
- Reset (any time, including mid-transfer): FSM -> IDLE, buffer and counters cleared, in-flight read discarded; outputs busy=0, done=0, sram_en=0, sram_wen=1, sram_addr=0, out_valid=0, out_last=0, out_data=0.

## Timing
- start accepted at edge k: busy=1 and first sram_en=1 from k to k+1; data captured at k+2; out_valid=1 from k+2.
- With out_ready held 1: one word per cycle sustained; words on cycles k+2 .. k+len+1; done=1 in the cycle after the last handshake edge; busy falls together with done rising.
- out_ready=0: out_valid and out_data stay stable; at most 2 words buffered, reads stall (sram_en=0) until space frees.
- New start may be accepted in the cycle done=1 (busy=0).

## Configuration
- Macro STREAM_REVERSE_EN.
- Defined: addresses issued descending, base+len-1 down to base (modulo 2^ADDR_W), so most-significant limb streams first; out_last marks the word at base.
- Undefined: ascending order from base as above.

## Test plan
- Reset mid-RUN with 2 words buffered -> all outputs to reset values immediately; no out_valid or done after reset release until new start.
- base=0x10, len=4, SRAM[0x10..0x13]=0xA0..0xA3, out_ready=1 -> out_data A0,A1,A2,A3 on cycles k+2..k+5, out_last with A3, done at k+6.
- Same transfer, out_ready toggling 1,0,0,1,... -> identical word order, no duplicates/drops, sram_en never high with 2 entries held and one in flight.
- base=0xFE, len=4 -> sram_addr sequence 0xFE,0xFF,0x00,0x01; len=256, base=0 -> 256 words, last from 0xFF.
- len=0 -> no sram_en, done pulse one cycle later; start during busy -> ignored, transfer unaffected.
- STREAM_REVERSE_EN defined, base=0x10, len=3 -> addresses 0x12,0x11,0x10; out_last with word from 0x10.

Source files
------------

// File: rtl/sram_read_streamer.sv
// rtl/sram_read_streamer.sv - SRAM read sequencer with 2-entry prefetch buffer feeding a valid/ready stream
// Optional feature macro STREAM_REVERSE_EN: stream addresses from base+len-1 down to base.
module sram_read_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   ptr, addr_hold, start_ptr, ptr_next;
    logic [ADDR_W:0]     issue_cnt, rem_cnt;
    logic                inflight;
    logic [DATA_W-1:0]   buf_data [2];
    logic                rd_idx, wr_idx;
    logic [1:0]          count, occ;
    logic                accept, issue, push, pop, done_set;

`ifdef STREAM_REVERSE_EN
    assign start_ptr = base + len[ADDR_W-1:0] - ADDR_ONE;
    assign ptr_next  = ptr - ADDR_ONE;
`else
    assign start_ptr = base;
    assign ptr_next  = ptr + ADDR_ONE;
`endif

    assign out_valid = (count != 2'd0);
    assign out_data  = buf_data[rd_idx];
    assign out_last  = out_valid && (rem_cnt == CNT_ONE);
    assign pop       = out_valid && out_ready;
    assign push      = inflight;
    assign busy      = (state != IDLE);
    assign sram_wen  = 1'b1;
    assign sram_en   = issue;
    assign sram_addr = issue ? ptr : addr_hold;

    // A word leaving this cycle frees its slot in time for the new read, which keeps one word per cycle.
    assign occ = count - {1'b0, pop} + {1'b0, inflight};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            RUN: begin
                issue = (issue_cnt != '0) && (occ < 2'd2);
                if (issue && issue_cnt == CNT_ONE)
                    state_next = FLUSH;
            end
            FLUSH: begin
                if (pop && out_last) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            addr_hold   <= '0;
            issue_cnt   <= '0;
            rem_cnt     <= '0;
            inflight    <= 1'b0;
            rd_idx      <= 1'b0;
            wr_idx      <= 1'b0;
            count       <= 2'd0;
            done        <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
        end else begin
            state    <= state_next;
            done     <= done_set;
            inflight <= issue;
            if (accept) begin
                ptr       <= start_ptr;
                issue_cnt <= len;
                rem_cnt   <= len;
            end else begin
                if (issue) begin
                    ptr       <= ptr_next;
                    addr_hold <= ptr;
                    issue_cnt <= issue_cnt - CNT_ONE;
                end
                if (pop)
                    rem_cnt <= rem_cnt - CNT_ONE;
            end
            if (push) begin
                buf_data[wr_idx] <= sram_q;
                wr_idx           <= ~wr_idx;
            end
            if (pop)
                rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_read_streamer.sv
// tb/tb_sram_read_streamer.sv - randomized self-checking bench for sram_read_streamer with a queue-based stream model
module tb_sram_read_streamer;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, sram_en, sram_wen, out_valid, out_last;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_q = '0, out_data;
    logic [DW-1:0] mem [256];

    int errors = 0, checks = 0;
    int cyc = 0, rmode = 0, ridx = 0;

    sram_read_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_q(sram_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (sram_en) sram_q <= mem[sram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready
    initial forever begin
        @(posedge clk); #1;
        ridx++;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (ridx % 3 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Reference model: a transfer is the list of addresses it must read and the words it must emit
    logic [AW-1:0] exp_addr [$];
    logic [DW:0]   exp_word [$];
    logic [AW-1:0] issued [$];
    logic [DW-1:0] hs_data [$];
    int            hs_cyc [$];
    bit            m_busy = 0, m_done = 0, prev_stall = 0;
    int            outstanding = 0, acc_cyc = 0, done_cyc = 0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        bit nb, nd, hs;
        logic [AW-1:0] a;
        if (!rst_n) begin
            exp_addr.delete();
            exp_word.delete();
            m_busy = 0; m_done = 0; prev_stall = 0; outstanding = 0;
        end else begin
            nb = m_busy; nd = 0;
            hs = out_valid && out_ready;
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("sram_wen", 64'(sram_wen), 64'd1);
            if (done) done_cyc = cyc;
            if (!m_busy) check("idle_quiet", 64'({out_valid, sram_en}), 64'd0);
            if (prev_stall) check("stall_hold", 64'({out_valid, out_data}), 64'({1'b1, prev_data}));
            if (sram_en) begin
                issued.push_back(sram_addr);
                check("occupancy", 64'((outstanding - int'(hs)) < 2), 64'd1);
                if (exp_addr.size() == 0) check("extra_read", 64'd1, 64'd0);
                else check("sram_addr", 64'(sram_addr), 64'(exp_addr.pop_front()));
                outstanding++;
            end
            if (out_valid) begin
                if (exp_word.size() == 0) check("extra_word", 64'd1, 64'd0);
                else begin
                    check("out_data", 64'(out_data), 64'(exp_word[0][DW-1:0]));
                    check("out_last", 64'(out_last), 64'(exp_word[0][DW]));
                    if (hs) begin
                        hs_cyc.push_back(cyc);
                        hs_data.push_back(out_data);
                        if (exp_word[0][DW]) begin nb = 0; nd = 1; end
                        void'(exp_word.pop_front());
                        outstanding--;
                    end
                end
            end
            if (start && !m_busy) begin
                acc_cyc = cyc;
                if (len == 0) nd = 1;
                else begin
                    nb = 1;
                    for (int i = 0; i < int'(len); i++) begin
`ifdef STREAM_REVERSE_EN
                        a = base + AW'(int'(len) - 1 - i);
`else
                        a = base + AW'(i);
`endif
                        exp_addr.push_back(a);
                        exp_word.push_back({i == int'(len) - 1, mem[a]});
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            m_busy = nb;
            m_done = nd;
        end
    end

    task automatic issue_start(input logic [AW-1:0] b, input logic [AW:0] l);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base = AW'($urandom); len = (AW+1)'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget && done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout", 64'(n < budget), 64'd1);
    endtask

    task automatic finish_xfer(input int budget);
        wait_done(budget);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        issued.delete(); hs_cyc.delete(); hs_data.delete();
    endtask

    logic [AW-1:0] wrap_exp [4];
    logic [DW-1:0] dir_exp [4];
    bit            any_activity;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + i;
`ifdef STREAM_REVERSE_EN
        wrap_exp = '{8'h01, 8'h00, 8'hFF, 8'hFE};
        dir_exp  = '{32'hA3, 32'hA2, 32'hA1, 32'hA0};
`else
        wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        dir_exp  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
`endif
        @(posedge clk); #1;
        check("reset_outputs",
              64'({busy, done, sram_en, sram_wen, sram_addr, out_valid, out_last, out_data}),
              64'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0}));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed transfer with a consumer that is always ready: exact cycle placement
        rmode = 0; clear_logs();
        issue_start(8'h10, 9'd4);
        finish_xfer(50);
        check("dir_count", 64'(hs_cyc.size()), 64'd4);
        if (hs_cyc.size() == 4) begin
            check("dir_first_cycle", 64'(hs_cyc[0] - acc_cyc), 64'd3);
            check("dir_last_cycle", 64'(hs_cyc[3] - acc_cyc), 64'd6);
            for (int i = 0; i < 4; i++) check("dir_word", 64'(hs_data[i]), 64'(dir_exp[i]));
        end
        check("dir_done_cycle", 64'(done_cyc - acc_cyc), 64'd7);

        // Same transfer under back-pressure
        rmode = 1; clear_logs();
        issue_start(8'h10, 9'd4);
        finish_xfer(100);
        check("bp_count", 64'(hs_data.size()), 64'd4);
        if (hs_data.size() == 4)
            for (int i = 0; i < 4; i++) check("bp_word", 64'(hs_data[i]), 64'(dir_exp[i]));

        // Address wrap at the top of the SRAM
        rmode = 2; clear_logs();
        issue_start(8'hFE, 9'd4);
        finish_xfer(100);
        check("wrap_count", 64'(issued.size()), 64'd4);
        if (issued.size() == 4)
            for (int i = 0; i < 4; i++) check("wrap_addr", 64'(issued[i]), 64'(wrap_exp[i]));

        // Full-depth transfer
        rmode = 2; clear_logs();
        issue_start(8'h00, 9'd256);
        finish_xfer(3000);
        check("full_reads", 64'(issued.size()), 64'd256);
        check("full_words", 64'(hs_data.size()), 64'd256);
        if (issued.size() == 256) begin
`ifdef STREAM_REVERSE_EN
            check("full_last_addr", 64'(issued[255]), 64'h00);
`else
            check("full_last_addr", 64'(issued[255]), 64'hFF);
`endif
        end

        // Zero-length command
        rmode = 0; clear_logs();
        issue_start(8'h33, 9'd0);
        finish_xfer(10);
        check("len0_reads", 64'(issued.size()), 64'd0);
        check("len0_done_cycle", 64'(done_cyc - acc_cyc), 64'd1);
        check("len0_done_width", 64'(done), 64'd0);

        // Start while busy must be ignored
        clear_logs();
        issue_start(8'h40, 9'd6);
        start = 1'b1; base = 8'h80; len = 9'd3;
        @(posedge clk); #1 start = 1'b0;
        finish_xfer(60);
        check("busy_start_reads", 64'(issued.size()), 64'd6);

        // Back-to-back: new command accepted in the done cycle
        clear_logs();
        issue_start(8'h20, 9'd2);
        wait_done(40);
        start = 1'b1; base = 8'h30; len = 9'd3;
        @(posedge clk); #1 start = 1'b0;
        finish_xfer(40);
        check("b2b_reads", 64'(issued.size()), 64'd5);

        // Random transfers
        for (int t = 0; t < 25; t++) begin
            for (int a = 0; a < 256; a++) mem[a] = $urandom;
            rmode = $urandom_range(0, 2);
            issue_start(AW'($urandom), (AW+1)'($urandom_range(1, 24)));
            finish_xfer(400);
        end

        // Reset mid-transfer with the buffer full
        rmode = 3;
        issue_start(8'h50, 9'd8);
        repeat (6) @(posedge clk);
        #1 check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs",
                 64'({busy, done, sram_en, sram_wen, sram_addr, out_valid, out_last, out_data}),
                 64'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0}));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rmode = 0;
        any_activity = 0;
        repeat (10) begin
            @(posedge clk); #1;
            any_activity |= out_valid | done | busy;
        end
        check("post_reset_quiet", 64'(any_activity), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
